// File: rtl/ahb_busreq_scheduler.sv
// AHB bus-request scheduler: tracks owner burst beats, arbitrates, drives grant/ho/hlockx.
// Define AHB_SCHED_RR_EN for round-robin arbitration; default build is fixed priority.
module ahb_busreq_scheduler #(
  parameter int NUM_MASTERS    = 5,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic [15:0] hbusreq,
  input  logic [15:0] hlock,
  input  logic        hready,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  output logic [15:0] grant,
  output logic        ho,
  output logic        hlockx,
  output logic [2:0]  cur_master
);

  typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;

  localparam logic [2:0]  DEF  = 3'(DEFAULT_MASTER);
  localparam logic [15:0] MASK = 16'((17'd1 << NUM_MASTERS) - 17'd1);
  localparam logic [1:0]  IDLE = 2'b00;
  localparam logic [1:0]  NSEQ = 2'b10;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt, burst_len;
  logic [2:0]  cur_nxt, win;
  logic        ho_nxt, hlockx_nxt;
  logic [15:0] req;
  logic        beat, owner_req, arb, found;
`ifdef AHB_SCHED_RR_EN
  logic [2:0]  ptr, ptr_nxt;
`endif

  assign req       = hbusreq & MASK;
  assign beat      = hready & htrans[1];
  assign owner_req = hbusreq[cur_master];

  // Arbitration only at burst boundaries, never mid-handover or under lock.
  assign arb = hready && !ho && (state != LOCKED) &&
               (((cnt == 5'd0) && (!owner_req || htrans == IDLE)) ||
                ((cnt == 5'd1) && beat));

  always_comb begin
    case (hburst)
      3'b000:         burst_len = 5'd1;
      3'b001:         burst_len = 5'd0;
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      default:        burst_len = 5'd16;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (beat) begin
      if (htrans == NSEQ) cnt_nxt = (burst_len == 5'd0) ? 5'd0 : burst_len - 5'd1;
      else                cnt_nxt = (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
    end
  end

  always_comb begin
    win   = DEF;
    found = 1'b0;
`ifdef AHB_SCHED_RR_EN
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx[3:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i[3:0]]) begin
        win   = i[2:0];
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur_master;
    hlockx_nxt = hlockx;
    ho_nxt     = ho & ~hready;
`ifdef AHB_SCHED_RR_EN
    ptr_nxt    = ptr;
`endif
    if (arb) begin
      if (!found) begin
        state_nxt  = PARK;
        hlockx_nxt = 1'b0;
        cur_nxt    = DEF;
      end else begin
        state_nxt  = hlock[win] ? LOCKED : OWN;
        hlockx_nxt = hlock[win];
        cur_nxt    = win;
      end
      if (cur_nxt != cur_master) begin
        ho_nxt = 1'b1;
`ifdef AHB_SCHED_RR_EN
        ptr_nxt = cur_nxt;
`endif
      end
    end else if (state == LOCKED && hready && !hlock[cur_master] && cnt == 5'd0) begin
      // Unlock now; the following cycle is an arbitration point.
      state_nxt  = OWN;
      hlockx_nxt = 1'b0;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      state      <= PARK;
      cnt        <= 5'd0;
      cur_master <= DEF;
      grant      <= 16'd1 << DEF;
      ho         <= 1'b0;
      hlockx     <= 1'b0;
`ifdef AHB_SCHED_RR_EN
      ptr        <= DEF;
`endif
    end else begin
      if (hready) begin
        state  <= state_nxt;
        ho     <= ho_nxt;
        hlockx <= hlockx_nxt;
      end
      cnt        <= cnt_nxt;
      cur_master <= cur_nxt;
      grant      <= 16'd1 << cur_nxt;
`ifdef AHB_SCHED_RR_EN
      ptr        <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_busreq_scheduler.sv
// Vector-table bench for ahb_busreq_scheduler; expected outputs flow through a scoreboard queue.
module tb_ahb_busreq_scheduler;

  localparam logic [1:0] ID = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic [15:0] hbusreq, hlock;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [15:0] grant;
  logic        ho, hlockx;
  logic [2:0]  cur_master;

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] lock;
    logic        rdy;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [15:0] eg;
    logic        eho;
    logic        elx;
  } vec_t;

  typedef struct {
    logic [15:0] g;
    logic        h;
    logic        lx;
    int          row;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  ahb_busreq_scheduler #(.NUM_MASTERS(5), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .hbusreq(hbusreq), .hlock(hlock),
    .hready(hready), .htrans(htrans), .hburst(hburst),
    .grant(grant), .ho(ho), .hlockx(hlockx), .cur_master(cur_master)
  );

  always #5 hclk = ~hclk;

  task automatic v(input logic r, input logic [15:0] rq, input logic [15:0] lk,
                   input logic rd, input logic [1:0] tr, input logic [2:0] bu,
                   input logic [15:0] g, input logic h, input logic lx);
    vec_t t;
    t.rst_n = r; t.req = rq; t.lock = lk; t.rdy = rd; t.trans = tr; t.burst = bu;
    t.eg = g; t.eho = h; t.elx = lx;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int row, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row=%0d got=0x%0h want=0x%0h", name, row, act, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [15:0] g);
    idx_of = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) idx_of = 3'(i);
  endfunction

  initial begin
    hrst_n = 1'b0; hbusreq = '0; hlock = '0; hready = 1'b1; htrans = ID; hburst = SINGLE;

    // reset with idle bus
    v(0, 16'h00, 0, 1, ID, 0, 16'h01, 0, 0);
    v(0, 16'h00, 0, 1, ID, 0, 16'h01, 0, 0);
    v(1, 16'h00, 0, 1, ID, 0, 16'h01, 0, 0);
`ifdef AHB_SCHED_RR_EN
    // round-robin over masters 0,1,4 with single transfers
    v(1, 16'h13, 0, 1, ID, 0,      16'h02, 1, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h02, 0, 0);
    v(1, 16'h13, 0, 1, NS, SINGLE, 16'h02, 0, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h10, 1, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h10, 0, 0);
    v(1, 16'h13, 0, 1, NS, SINGLE, 16'h10, 0, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h01, 1, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h01, 0, 0);
    v(1, 16'h13, 0, 1, NS, SINGLE, 16'h01, 0, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h02, 1, 0);
    v(1, 16'h13, 0, 1, ID, 0,      16'h02, 0, 0);
`else
    // simple request/handover
    v(1, 16'h04, 0, 1, ID, 0, 16'h04, 1, 0);
    v(1, 16'h04, 0, 1, ID, 0, 16'h04, 0, 0);
    v(1, 16'h04, 0, 1, ID, 0, 16'h04, 0, 0);
    // master 1 INCR4 with a wait state, master 3 waiting
    v(1, 16'h0A, 0, 1, ID, 0,     16'h02, 1, 0);
    v(1, 16'h0A, 0, 1, ID, 0,     16'h02, 0, 0);
    v(1, 16'h0A, 0, 1, NS, INCR4, 16'h02, 0, 0);
    v(1, 16'h08, 0, 1, SQ, INCR4, 16'h02, 0, 0);
    v(1, 16'h08, 0, 0, SQ, INCR4, 16'h02, 0, 0);
    v(1, 16'h08, 0, 1, SQ, INCR4, 16'h02, 0, 0);
    v(1, 16'h08, 0, 1, SQ, INCR4, 16'h08, 1, 0);
    v(1, 16'h08, 0, 1, ID, 0,     16'h08, 0, 0);
    // locked INCR8 by master 2 while master 0 waits
    v(1, 16'h04, 16'h04, 1, ID, 0,     16'h04, 1, 1);
    v(1, 16'h05, 16'h04, 1, ID, 0,     16'h04, 0, 1);
    v(1, 16'h05, 16'h04, 1, NS, INCR8, 16'h04, 0, 1);
    for (int i = 0; i < 7; i++) v(1, 16'h05, 16'h04, 1, SQ, INCR8, 16'h04, 0, 1);
    v(1, 16'h05, 16'h04, 1, ID, 0, 16'h04, 0, 1);
    v(1, 16'h01, 16'h00, 1, ID, 0, 16'h04, 0, 0);
    v(1, 16'h01, 16'h00, 1, ID, 0, 16'h01, 1, 0);
    v(1, 16'h01, 16'h00, 1, ID, 0, 16'h01, 0, 0);
    // fixed priority: master 0 keeps winning
    for (int i = 0; i < 3; i++) begin
      v(1, 16'h13, 0, 1, NS, SINGLE, 16'h01, 0, 0);
      v(1, 16'h13, 0, 1, ID, 0,      16'h01, 0, 0);
    end
    // reset in the middle of master 3 INCR16
    v(1, 16'h08, 0, 1, ID, 0,      16'h08, 1, 0);
    v(1, 16'h08, 0, 1, ID, 0,      16'h08, 0, 0);
    v(1, 16'h08, 0, 1, NS, INCR16, 16'h08, 0, 0);
    v(1, 16'h08, 0, 1, SQ, INCR16, 16'h08, 0, 0);
    v(1, 16'h08, 0, 1, SQ, INCR16, 16'h08, 0, 0);
    v(0, 16'h08, 0, 1, SQ, INCR16, 16'h01, 0, 0);
    v(1, 16'h02, 0, 1, ID, 0,      16'h02, 1, 0);
    v(1, 16'h02, 0, 1, ID, 0,      16'h02, 0, 0);
    // ho held through hready=0; requests above NUM_MASTERS ignored
    v(1, 16'h10, 0, 1, ID, 0, 16'h10, 1, 0);
    v(1, 16'h10, 0, 0, ID, 0, 16'h10, 1, 0);
    v(1, 16'h10, 0, 1, ID, 0, 16'h10, 0, 0);
    v(1, 16'h20, 0, 1, ID, 0, 16'h01, 1, 0);
    v(1, 16'h00, 0, 1, ID, 0, 16'h01, 0, 0);
`endif

    @(negedge hclk);
    for (int r = 0; r < vecs.size(); r++) begin
      exp_t e;
      exp_t got;
      hrst_n = vecs[r].rst_n; hbusreq = vecs[r].req; hlock = vecs[r].lock;
      hready = vecs[r].rdy; htrans = vecs[r].trans; hburst = vecs[r].burst;
      e.g = vecs[r].eg; e.h = vecs[r].eho; e.lx = vecs[r].elx; e.row = r;
      sb.push_back(e);
      @(posedge hclk);
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty row=%0d got=0 want=1", r);
      end else begin
        got = sb.pop_front();
        check("grant",      got.row, int'(grant),      int'(got.g));
        check("ho",         got.row, int'(ho),         int'(got.h));
        check("hlockx",     got.row, int'(hlockx),     int'(got.lx));
        check("cur_master", got.row, int'(cur_master), int'(idx_of(got.g)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
